// File: rtl/inst_fetch_buffer_pkg.sv
// Shared types for the instruction fetch stage: FSM states, FIFO entry layout,
// default reset PC and PC alignment helper.
package inst_fetch_buffer_pkg;

    typedef enum logic [1:0] {
        S_BOOT = 2'd0,
        S_RUN  = 2'd1,
        S_FULL = 2'd2
    } fetch_state_t;

    localparam logic [31:0] DEF_RESET_PC = 32'h0000_0000;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
    } fetch_entry_t;

    localparam int ENTRY_W = $bits(fetch_entry_t);

    function automatic logic [31:0] align_pc(input logic [31:0] pc);
        return pc & 32'hFFFF_FFFC;
    endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Generic synchronous FIFO; flush empties it and takes priority over push.
module fetch_fifo #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 4,
    parameter int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic             flush,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic [CNT_W-1:0] count,
    output logic             full,
    output logic             empty
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr, rd_ptr;
    logic             do_push, do_pop;

    assign full    = (count == DEPTH_C);
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign dout    = mem[rd_ptr];

    // Storage is reset so the head reads as zero out of reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= din;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (do_pop) rd_ptr <= rd_ptr + 1'b1;
            count <= count + CNT_W'(do_push) - CNT_W'(do_pop);
        end
    end

endmodule

// File: rtl/inst_fetch_buffer.sv
// Fetch stage: owns the fetch PC, issues ROM reads, buffers {pc,inst} for the decoder.
// Optional FETCH_BYPASS_EN forwards a response straight to the decoder when the FIFO is empty.
module inst_fetch_buffer
    import inst_fetch_buffer_pkg::*;
#(
    parameter int          DEPTH    = 4,
    parameter int          ADDR_W   = 11,
    parameter logic [31:0] RESET_PC = DEF_RESET_PC
) (
    input  logic                         clk,
    input  logic                         rst,
    output logic                         rom_en,
    output logic [ADDR_W-1:0]            rom_addr,
    input  logic [31:0]                  rom_inst,
    input  logic                         redirect_valid,
    input  logic [31:0]                  redirect_pc,
    output logic                         inst_valid,
    input  logic                         inst_ready,
    output logic [31:0]                  inst_out,
    output logic [31:0]                  inst_pc,
    output logic [$clog2(DEPTH+1)-1:0]   buf_count
);

    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

    fetch_state_t state_q, state_d;

    logic [31:0]        fetch_pc, issued_pc;
    logic               inflight;
    logic               flush, resp_vld, push, fifo_pop, byp_hit;
    logic               fifo_full, fifo_empty;
    logic [CNT_W-1:0]   count, count_next, occ, occ_next;
    logic [ENTRY_W-1:0] dout_raw;
    fetch_entry_t       din, head;

    // A redirect squashes the response arriving this cycle; S_BOOT ignores redirects.
    assign flush    = redirect_valid && (state_q != S_BOOT);
    assign resp_vld = inflight && !flush;

`ifdef FETCH_BYPASS_EN
    assign byp_hit = resp_vld && fifo_empty;
    assign push    = resp_vld && !(byp_hit && inst_ready);
`else
    assign byp_hit = 1'b0;
    assign push    = resp_vld;
`endif

    assign din      = '{pc: issued_pc, inst: rom_inst};
    assign head     = fetch_entry_t'(dout_raw);
    assign fifo_pop = !fifo_empty && inst_ready;

    assign inst_valid = !fifo_empty || byp_hit;
    assign inst_out   = byp_hit ? rom_inst  : head.inst;
    assign inst_pc    = byp_hit ? issued_pc : head.pc;
    assign buf_count  = count;
    assign rom_addr   = fetch_pc[ADDR_W+1:2];

    // Credit: buffered entries plus the outstanding read must leave a free slot.
    assign occ        = count + CNT_W'(inflight);
    assign rom_en     = (state_q == S_RUN) && !redirect_valid && (occ < DEPTH_C) && !fifo_full;
    assign count_next = flush ? '0 : count + CNT_W'(push) - CNT_W'(fifo_pop);
    assign occ_next   = count_next + CNT_W'(rom_en);

    fetch_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (DEPTH),
        .CNT_W (CNT_W)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (fifo_pop),
        .flush (flush),
        .din   (din),
        .dout  (dout_raw),
        .count (count),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= S_BOOT;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_BOOT: state_d = S_RUN;
            S_RUN: begin
                if (flush)                   state_d = S_RUN;
                else if (occ_next >= DEPTH_C) state_d = S_FULL;
            end
            S_FULL: begin
                if (flush || occ_next < DEPTH_C) state_d = S_RUN;
            end
            default: state_d = S_BOOT;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fetch_pc  <= RESET_PC;
            issued_pc <= RESET_PC;
            inflight  <= 1'b0;
        end else begin
            inflight <= rom_en;
            if (flush) begin
                fetch_pc <= align_pc(redirect_pc);
            end else if (rom_en) begin
                issued_pc <= fetch_pc;
                fetch_pc  <= fetch_pc + 32'd4;
            end
        end
    end

    assert property (@(posedge clk) disable iff (rst) !(push && fifo_full));

endmodule

// File: tb/tb_inst_fetch_buffer.sv
// Directed + random bench for inst_fetch_buffer against a queue-based fetch model.
module tb_inst_fetch_buffer;

    localparam int          DEPTH    = 4;
    localparam int          ADDR_W   = 11;
    localparam logic [31:0] RESET_PC = 32'h0;
`ifdef FETCH_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              rst;
    logic              rom_en;
    logic [ADDR_W-1:0] rom_addr;
    logic [31:0]       rom_inst = 32'h0;
    logic              redirect_valid;
    logic [31:0]       redirect_pc;
    logic              inst_valid;
    logic              inst_ready;
    logic [31:0]       inst_out;
    logic [31:0]       inst_pc;
    logic [2:0]        buf_count;

    inst_fetch_buffer #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .RESET_PC(RESET_PC)) dut (
        .clk(clk), .rst(rst), .rom_en(rom_en), .rom_addr(rom_addr), .rom_inst(rom_inst),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .inst_valid(inst_valid), .inst_ready(inst_ready), .inst_out(inst_out),
        .inst_pc(inst_pc), .buf_count(buf_count)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] rom_word(input logic [31:0] pc);
        return 32'hA000_0000 + ((pc >> 2) & 32'h7FF);
    endfunction

    // Synchronous ROM: ROM[i] = 0xA000_0000 + i
    always @(posedge clk) if (rom_en) rom_inst <= 32'hA000_0000 + 32'(rom_addr);

    int          total = 0, bad = 0;
    int          cyc, first_issue, first_valid;
    logic [31:0] mq[$];
    bit          pend, booted;
    logic [31:0] ppc, mpc;
    logic [31:0] vq[$], vi[$], aq[$];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        pend = 0; booted = 0; mpc = RESET_PC; ppc = 0;
        cyc = 0; first_issue = -1; first_valid = -1;
    endtask

    // One cycle: drive inputs, check outputs against the model, advance the model.
    task automatic step(input bit rdv, input logic [31:0] rpc, input bit rdy);
        bit redir, byp, ev, erom;
        logic [31:0] epc;
        @(negedge clk);
        redirect_valid = rdv; redirect_pc = rpc; inst_ready = rdy;
        #1;
        redir = rdv && booted;
        byp   = BYP && mq.size() == 0 && pend && !redir;
        ev    = mq.size() > 0 || byp;
        epc   = mq.size() > 0 ? mq[0] : ppc;
        erom  = booted && !redir && (mq.size() + int'(pend) < DEPTH);
        chk("rom_en", 32'(rom_en), 32'(erom));
        chk("rom_addr", 32'(rom_addr), (mpc >> 2) & 32'h7FF);
        chk("inst_valid", 32'(inst_valid), 32'(ev));
        chk("buf_count", 32'(buf_count), mq.size());
        if (ev) begin
            chk("inst_pc", inst_pc, epc);
            chk("inst_out", inst_out, rom_word(epc));
        end
        if (rom_en && first_issue < 0) first_issue = cyc;
        if (inst_valid && first_valid < 0) first_valid = cyc;
        if (inst_valid) begin vq.push_back(inst_pc); vi.push_back(inst_out); end
        if (rom_en) aq.push_back(32'(rom_addr));
        cyc++;
        if (redir) begin
            mq.delete(); pend = 0; mpc = rpc & 32'hFFFF_FFFC;
        end else begin
            if (ev && rdy && mq.size() > 0) void'(mq.pop_front());
            if (pend && !(byp && rdy)) mq.push_back(ppc);
            pend = erom;
            if (erom) begin ppc = mpc; mpc = mpc + 32'd4; end
        end
        booted = 1;
    endtask

    task automatic clear_log();
        vq.delete(); vi.delete(); aq.delete();
    endtask

    function automatic logic [31:0] at(input logic [31:0] q[$], input int i);
        return (q.size() > i) ? q[i] : 32'hxxxx_xxxx;
    endfunction

    initial begin
        rst = 1'b1; redirect_valid = 0; redirect_pc = 0; inst_ready = 0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        chk("rst_rom_en", 32'(rom_en), 0);
        chk("rst_rom_addr", 32'(rom_addr), 0);
        chk("rst_valid", 32'(inst_valid), 0);
        chk("rst_inst_out", inst_out, 0);
        chk("rst_inst_pc", inst_pc, 0);
        chk("rst_count", 32'(buf_count), 0);
        @(posedge clk); #2 rst = 1'b0;

        // 1: streaming with ready=1
        clear_log();
        repeat (12) step(0, 0, 1);
        chk("first_issue", first_issue, 1);
        chk("first_valid", first_valid, BYP ? 2 : 3);
        chk("first_addr", at(aq, 0), 0);
        chk("stream_pc0", at(vq, 0), 32'h0);
        chk("stream_pc1", at(vq, 1), 32'h4);
        chk("stream_pc2", at(vq, 2), 32'h8);

        // 2: back-pressure fills the buffer
        repeat (10) step(0, 0, 0);
        chk("full_count", 32'(buf_count), 4);
        chk("full_rom_en", 32'(rom_en), 0);
        repeat (8) step(0, 0, 1);

        // 3: redirect with 3 buffered and one in flight
        for (int i = 0; i < 8 && !(mq.size() == 3 && pend); i++) step(0, 0, 0);
        step(1, 32'h0000_0100, 0);
        clear_log();
        step(0, 0, 1);
        chk("redir_flush", 32'(buf_count), 0);
        repeat (5) step(0, 0, 1);
        chk("redir_pc", at(vq, 0), 32'h100);
        chk("redir_inst", at(vi, 0), 32'hA000_0040);

        // 4: unaligned target and PC wrap
        step(1, 32'h0000_0103, 1);
        clear_log();
        repeat (5) step(0, 0, 1);
        chk("r103_addr", at(aq, 0), 32'h40);
        chk("r103_pc", at(vq, 0), 32'h100);
        step(1, 32'hFFFF_FFFC, 1);
        clear_log();
        repeat (6) step(0, 0, 1);
        chk("wrap_addr0", at(aq, 0), 32'h7FF);
        chk("wrap_addr1", at(aq, 1), 32'h0);
        chk("wrap_pc0", at(vq, 0), 32'hFFFF_FFFC);
        chk("wrap_pc1", at(vq, 1), 32'h0);

        // 5: redirect while the head is being consumed
        for (int i = 0; i < 8 && mq.size() == 0; i++) step(0, 0, 0);
        step(1, 32'h0000_0200, 1);
        clear_log();
        repeat (5) step(0, 0, 1);
        chk("redir_xfer_pc", at(vq, 0), 32'h200);

        // random traffic
        for (int i = 0; i < 400; i++) begin
            bit rdv, rdy;
            rdv = ($urandom_range(0, 99) < 6);
            rdy = ($urandom_range(0, 99) < 70);
            step(rdv, $urandom, rdy);
        end

        // 6: asynchronous reset between edges
        repeat (4) step(0, 0, 0);
        #1 rst = 1'b1;
        #1;
        chk("arst_valid", 32'(inst_valid), 0);
        chk("arst_count", 32'(buf_count), 0);
        chk("arst_rom_en", 32'(rom_en), 0);
        chk("arst_addr", 32'(rom_addr), (RESET_PC >> 2) & 32'h7FF);
        @(posedge clk); #2 rst = 1'b0;
        model_reset();
        clear_log();
        repeat (8) step(0, 0, 1);
        chk("restart_addr", at(aq, 0), (RESET_PC >> 2) & 32'h7FF);
        chk("restart_pc", at(vq, 0), RESET_PC);
        chk("restart_valid", first_valid, BYP ? 2 : 3);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
